// File: rtl/ripple_ctr_pkg.sv
// Shared types and default parameters for the ripple counter reader.
// Single cycle of nothing: purely declarations, no logic or flow control.
package ripple_ctr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH         = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;
    localparam int unsigned DEF_MAX_WAIT      = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independently asynchronous bits.
// Latency 2 cycles, no flow control; a multi-bit bus can still arrive torn.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q, meta_d;
    logic [Width-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ripple_ctr_reader.sv
// Captures a stable ripple-counter value on request and reports count/delta/wrap.
// Result 1 cycle after a stable request (up to MaxWait in SETTLE); held in HOLD until ready_i.
module ripple_ctr_reader
    import ripple_ctr_pkg::*;
#(
    parameter int unsigned Width        = DEF_WIDTH,
    parameter int unsigned SettleCycles = DEF_SETTLE_CYCLES,
    parameter int unsigned MaxWait      = DEF_MAX_WAIT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] cnt_i,
    input  logic             req_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] count_o,
    output logic [Width-1:0] delta_o,
    output logic             wrap_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int unsigned StabW = $clog2(SettleCycles + 1);
    localparam int unsigned WaitW = $clog2(MaxWait);
    localparam logic [StabW-1:0] StabMax  = StabW'(SettleCycles);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MaxWait - 1);

    logic [Width-1:0] sync_q;

    state_e           state_q, state_d;
    logic [Width-1:0] prev_q, prev_d;
    logic [StabW-1:0] stab_q, stab_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [Width-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic [Width-1:0] count_q, count_d;
    logic [Width-1:0] delta_q, delta_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             stable;
    logic             capture;
    logic             cap_err;

    sync_2ff #(
        .Width (Width)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (cnt_i),
        .q_o   (sync_q)
    );

    // Stability tracking runs regardless of FSM state so a request can hit an already-settled value.
    always_comb begin
        prev_d = sync_q;
        if (sync_q != prev_q) begin
            stab_d = '0;
        end else if (stab_q != StabMax) begin
            stab_d = stab_q + 1'b1;
        end else begin
            stab_d = stab_q;
        end
    end

    assign stable = (stab_q == StabMax);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        last_d  = last_q;
        valid_d = valid_q;
        count_d = count_q;
        delta_d = delta_q;
        wrap_d  = wrap_q;
        err_d   = err_q;
        capture = 1'b0;
        cap_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (stable) begin
                        capture = 1'b1;
                    end else begin
                        state_d = SETTLE;
                        wait_d  = '0;
                    end
                end
            end
            SETTLE: begin
                if (stable) begin
                    capture = 1'b1;
                end else if (wait_q == WaitLast) begin
                    capture = 1'b1;
                    cap_err = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // A forced capture may be torn, so it must not become the reference for the next delta.
        if (capture) begin
            state_d = HOLD;
            valid_d = 1'b1;
            count_d = sync_q;
            delta_d = sync_q - last_q;
            wrap_d  = (sync_q < last_q);
            err_d   = cap_err;
            if (!cap_err) begin
                last_d = sync_q;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prev_q  <= '0;
            stab_q  <= '0;
            wait_q  <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            delta_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            stab_q  <= stab_d;
            wait_q  <= wait_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            count_q <= count_d;
            delta_q <= delta_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign valid_o = valid_q;
    assign count_o = count_q;
    assign delta_o = delta_q;
    assign wrap_o  = wrap_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_ripple_ctr_reader.sv
// Directed bench for ripple_ctr_reader: inputs driven and outputs sampled on the falling edge.
module tb_ripple_ctr_reader;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b0;
    logic [3:0] cnt_i   = 4'd0;
    logic       req_i   = 1'b0;
    logic       ready_i = 1'b0;
    logic       valid_o;
    logic [3:0] count_o;
    logic [3:0] delta_o;
    logic       wrap_o;
    logic       err_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;
    bit alt_en   = 1'b0;

    always #5 clk_i = ~clk_i;

    ripple_ctr_reader #(
        .Width        (4),
        .SettleCycles (2),
        .MaxWait      (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cnt_i   (cnt_i),
        .req_i   (req_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .count_o (count_o),
        .delta_o (delta_o),
        .wrap_o  (wrap_o),
        .err_o   (err_o),
        .busy_o  (busy_o)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One full clock; cnt_i alternates 7/8 on every falling edge while alt_en is set.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        if (alt_en) cnt_i = (cnt_i == 4'd7) ? 4'd8 : 4'd7;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic do_read(input string tag, input int lat, input int cnt, input int dlt,
                           input int wr, input int er);
        int n;
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        n = 1;
        while (!valid_o && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_lat"},   n, lat);
        check_eq({tag, "_count"}, count_o, cnt);
        check_eq({tag, "_delta"}, delta_o, dlt);
        check_eq({tag, "_wrap"},  wrap_o, wr);
        check_eq({tag, "_err"},   err_o, er);
        check_eq({tag, "_busy"},  busy_o, 1);
    endtask

    task automatic accept(input string tag);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_eq({tag, "_drop"}, valid_o, 0);
        check_eq({tag, "_idle"}, busy_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, valid_o, 0);
        check_eq({tag, "_busy"},  busy_o, 0);
        check_eq({tag, "_count"}, count_o, 0);
        check_eq({tag, "_delta"}, delta_o, 0);
        check_eq({tag, "_wrap"},  wrap_o, 0);
        check_eq({tag, "_err"},   err_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen;
        #1 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_all_zero("rst0");
        rst_i = 1'b0;

        // First read from a cleared reference
        cnt_i = 4'd5;
        wait_cycles(10);
        do_read("t2", 1, 5, 5, 0, 0);
        tick();
        check_eq("t2_held", valid_o, 1);
        accept("t2");

        // Wrap, then equal count
        cnt_i = 4'd3;
        wait_cycles(10);
        do_read("t3", 1, 3, 14, 1, 0);
        accept("t3");
        do_read("t3_eq", 1, 3, 0, 0, 0);
        accept("t3_eq");
        cnt_i = 4'd5;
        wait_cycles(10);
        do_read("t3_fwd", 1, 5, 2, 0, 0);
        accept("t3_fwd");

        // Never-stable input: timeout after 16 SETTLE cycles, value at edge 20 is 8
        cnt_i  = 4'd7;
        alt_en = 1'b1;
        wait_cycles(3);
        do_read("t4", 17, 8, 3, 0, 1);
        alt_en = 1'b0;
        accept("t4");
        cnt_i = 4'd9;
        wait_cycles(10);
        do_read("t4_next", 1, 9, 4, 0, 0);
        accept("t4_next");

        // Backpressure with a moving counter and ignored requests
        cnt_i = 4'd6;
        wait_cycles(10);
        do_read("t5", 1, 6, 13, 1, 0);
        cnt_i = 4'd11;
        for (int i = 0; i < 5; i++) begin
            req_i = (i == 2);
            tick();
        end
        req_i = 1'b0;
        check_eq("t5_valid_held", valid_o, 1);
        check_eq("t5_count_held", count_o, 6);
        check_eq("t5_delta_held", delta_o, 13);
        ready_i = 1'b1;
        req_i   = 1'b1;
        tick();
        ready_i = 1'b0;
        req_i   = 1'b0;
        check_eq("t5_drop", valid_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_o || busy_o) seen = 1'b1;
        end
        check_eq("t5_no_second", seen, 0);

        // Request lands while the new value is still settling after the synchroniser
        cnt_i = 4'd4;
        wait_cycles(10);
        cnt_i = 4'd5;
        wait_cycles(3);
        do_read("t6", 3, 5, 15, 1, 0);
        accept("t6");

        // Reset while in SETTLE
        cnt_i = 4'd12;
        wait_cycles(3);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        check_eq("t1_settle_busy", busy_o, 1);
        check_eq("t1_settle_valid", valid_o, 0);
        rst_i = 1'b1;
        #1;
        check_all_zero("t1_rst");
        tick();
        rst_i = 1'b0;
        tick();
        check_eq("t1_post_busy", busy_o, 0);
        cnt_i = 4'd2;
        wait_cycles(10);
        do_read("t1", 1, 2, 2, 0, 0);
        accept("t1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
